// File: rtl/seg_pkg.sv
// Glyph constants and nibble-to-segment decode for active-low seven-segment displays.
// Bit order is {G,F,E,D,C,B,A}; a 0 lights the segment.
package seg_pkg;

    localparam logic [6:0] SEG_0    = 7'h40;
    localparam logic [6:0] SEG_1    = 7'h79;
    localparam logic [6:0] SEG_2    = 7'h24;
    localparam logic [6:0] SEG_3    = 7'h30;
    localparam logic [6:0] SEG_4    = 7'h19;
    localparam logic [6:0] SEG_5    = 7'h12;
    localparam logic [6:0] SEG_6    = 7'h02;
    localparam logic [6:0] SEG_7    = 7'h78;
    localparam logic [6:0] SEG_8    = 7'h00;
    localparam logic [6:0] SEG_9    = 7'h10;
    localparam logic [6:0] SEG_HA   = 7'h08;
    localparam logic [6:0] SEG_HB   = 7'h03;
    localparam logic [6:0] SEG_HC   = 7'h46;
    localparam logic [6:0] SEG_HD   = 7'h21;
    localparam logic [6:0] SEG_HE   = 7'h06;
    localparam logic [6:0] SEG_HF   = 7'h0E;
    localparam logic [6:0] SEG_DASH = 7'h3F;
    localparam logic [6:0] SEG_OFF  = 7'h7F;

    // In decimal mode nibble A renders as a dash and B..F stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nibble, input logic hex);
        logic [6:0] seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = hex ? SEG_HA : SEG_DASH;
            4'hB:    seg = hex ? SEG_HB : SEG_OFF;
            4'hC:    seg = hex ? SEG_HC : SEG_OFF;
            4'hD:    seg = hex ? SEG_HD : SEG_OFF;
            4'hE:    seg = hex ? SEG_HE : SEG_OFF;
            default: seg = hex ? SEG_HF : SEG_OFF;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational nibble + glyph mode to active-low segment pattern.
module seg_glyph_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex,
    output logic [6:0] seg
);

    assign seg = seg_decode(nibble, hex);

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed common-anode seven-segment driver: frame-latched inputs,
// per-slot dead-time, leading-zero suppression and registered pin outputs.
module seg_scan_display
    import seg_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int DEAD   = 500
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [4*DIGITS-1:0]   i_data,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic [DIGITS-1:0]     i_blank,
    input  logic                  i_hex,
    input  logic                  i_lzs,
    output logic [6:0]            o_seg,
    output logic                  o_dp,
    output logic [DIGITS-1:0]     o_sel
);

    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]          cnt;
    logic [IW-1:0]          idx;
    logic [4*DIGITS-1:0]    sh_data;
    logic [DIGITS-1:0]      sh_dp;
    logic [DIGITS-1:0]      sh_blank;
    logic                   sh_hex;
    logic                   sh_lzs;

    logic                   frame_end;
    logic                   in_dead;
    logic [DIGITS-1:0]      suppress;
    logic                   zero_run;
    logic [3:0]             cur_nib;
    logic [6:0]             dec_seg;
    logic                   cur_dark;

    assign frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);

    generate
        if (DEAD == 0) begin : g_no_dead
            assign in_dead = 1'b0;
        end else begin : g_dead
            assign in_dead = (cnt < CW'(DEAD));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Shadow blank resets to all ones so the first frame after reset is dark.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sh_data  <= '0;
            sh_dp    <= '0;
            sh_blank <= '1;
            sh_hex   <= 1'b0;
            sh_lzs   <= 1'b0;
        end else if (frame_end) begin
            sh_data  <= i_data;
            sh_dp    <= i_dp;
            sh_blank <= i_blank;
            sh_hex   <= i_hex;
            sh_lzs   <= i_lzs;
        end
    end

    // Walk down from the top digit; a digit is suppressed while everything above it is zero.
    always_comb begin
        suppress = '0;
        zero_run = sh_lzs;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run    = zero_run && (sh_data[4*k +: 4] == 4'h0);
            suppress[k] = zero_run;
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx) begin
                cur_nib = sh_data[4*k +: 4];
            end
        end
    end

    seg_glyph_decode u_glyph (
        .nibble (cur_nib),
        .hex    (sh_hex),
        .seg    (dec_seg)
    );

    assign cur_dark = sh_blank[idx] | suppress[idx];

    // Blanked digits keep their select low so every digit sees the same duty cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sel <= '1;
            o_seg <= SEG_OFF;
            o_dp  <= 1'b1;
        end else if (in_dead) begin
            o_sel <= '1;
            o_seg <= SEG_OFF;
            o_dp  <= 1'b1;
        end else begin
            o_sel <= ~({{(DIGITS-1){1'b0}}, 1'b1} << idx);
            o_seg <= cur_dark ? SEG_OFF : dec_seg;
            o_dp  <= ~(sh_dp[idx] & ~sh_blank[idx]);
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: vector table, corner sequences and
// randomized traffic against a frame-position reference model.
module tb_seg_scan_display;

    localparam int DIG_T = 4;
    localparam int DIV_T = 4;
    localparam int FRAME = DIG_T * DIV_T;

    localparam logic [6:0] DEC_G [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h3F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    localparam logic [6:0] HEX_G [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk;
    logic        rst_n;
    logic [15:0] d_data;
    logic [3:0]  d_dp;
    logic [3:0]  d_blank;
    logic        d_hex;
    logic        d_lzs;
    logic [6:0]  seg_a, seg_b;
    logic        dp_a, dp_b;
    logic [3:0]  sel_a, sel_b;

    int checks;
    int failures;

    // Reference model state: edges since reset release and the frame-latched inputs.
    int          n_edges;
    logic [15:0] m_data;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    logic        m_hex;
    logic        m_lzs;

    seg_scan_display #(.DIGITS(DIG_T), .DIV(DIV_T), .DEAD(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d_data), .i_dp(d_dp), .i_blank(d_blank),
        .i_hex(d_hex), .i_lzs(d_lzs), .o_seg(seg_a), .o_dp(dp_a), .o_sel(sel_a)
    );

    seg_scan_display #(.DIGITS(DIG_T), .DIV(DIV_T), .DEAD(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data(d_data), .i_dp(d_dp), .i_blank(d_blank),
        .i_hex(d_hex), .i_lzs(d_lzs), .o_seg(seg_b), .o_dp(dp_b), .o_sel(sel_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  blank;
        logic        hex;
        logic        lzs;
        logic [27:0] seg_exp;   // {d3, d2, d1, d0}
        logic [3:0]  dp_exp;
    } vec_t;

    function automatic logic [11:0] model_out(int p, int dead);
        int c;
        int k;
        logic [6:0] s;
        logic dpo;
        c = p % DIV_T;
        k = (p / DIV_T) % DIG_T;
        if (c < dead) return {4'hF, 1'b1, 7'h7F};
        if (m_blank[k] || (m_lzs && k >= 1 && (m_data >> (4 * k)) == 16'h0)) s = 7'h7F;
        else if (m_hex) s = HEX_G[m_data[4*k +: 4]];
        else s = DEC_G[m_data[4*k +: 4]];
        dpo = !(m_dp[k] && !m_blank[k]);
        return {~(4'b0001 << k), dpo, s};
    endfunction

    task automatic model_reset();
        n_edges = 0;
        m_data  = 16'h0;
        m_dp    = 4'h0;
        m_blank = 4'hF;
        m_hex   = 1'b0;
        m_lzs   = 1'b0;
    endtask

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s @%0t: got sel=%h dp=%b seg=%h, expected sel=%h dp=%b seg=%h",
                     name, $time, act[11:8], act[7], act[6:0], exp[11:8], exp[7], exp[6:0]);
        end
    endtask

    // One clock: predict from pre-edge state, latch shadow on the frame-end edge, compare 1 ns later.
    task automatic step();
        logic [11:0] exp_a, exp_b;
        @(posedge clk);
        exp_a = model_out(n_edges, 1);
        exp_b = model_out(n_edges, 0);
        if ((n_edges % FRAME) == FRAME - 1) begin
            m_data  = d_data;
            m_dp    = d_dp;
            m_blank = d_blank;
            m_hex   = d_hex;
            m_lzs   = d_lzs;
        end
        n_edges++;
        #1;
        check("model_dead1", {sel_a, dp_a, seg_a}, exp_a);
        check("model_dead0", {sel_b, dp_b, seg_b}, exp_b);
    endtask

    task automatic to_frame_start();
        int guard;
        guard = 0;
        do begin
            step();
            guard++;
        end while (!((n_edges % FRAME) == 0 && n_edges > 0) && guard < 3 * FRAME);
        checks++;
        if (guard >= 3 * FRAME) begin
            failures++;
            $display("FAIL frame_sync: no frame boundary within %0d cycles", guard);
        end
    endtask

    task automatic apply_vec(input vec_t v, input int num);
        logic [3:0] sl;
        d_data  = v.data;
        d_dp    = v.dp;
        d_blank = v.blank;
        d_hex   = v.hex;
        d_lzs   = v.lzs;
        to_frame_start();
        for (int j = 0; j < FRAME; j++) begin
            step();
            sl = ~(4'b0001 << (j / DIV_T));
            if (j % DIV_T == 0)
                check($sformatf("vec%0d_dead", num), {sel_a, dp_a, seg_a}, {4'hF, 1'b1, 7'h7F});
            if (j % DIV_T == 2)
                check($sformatf("vec%0d_digit%0d", num, j / DIV_T), {sel_a, dp_a, seg_a},
                      {sl, v.dp_exp[j / DIV_T], v.seg_exp[7*(j / DIV_T) +: 7]});
        end
    endtask

    vec_t vecs [9];

    initial begin
        int guard;
        checks   = 0;
        failures = 0;
        model_reset();

        vecs[0] = '{16'h1234, 4'h0, 4'h0, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'hF};
        vecs[1] = '{16'hABCD, 4'h0, 4'h0, 1'b1, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}, 4'hF};
        vecs[2] = '{16'hABCD, 4'h0, 4'h0, 1'b0, 1'b0, {7'h3F, 7'h7F, 7'h7F, 7'h7F}, 4'hF};
        vecs[3] = '{16'h0050, 4'h0, 4'h0, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'hF};
        vecs[4] = '{16'h0000, 4'h0, 4'h0, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'hF};
        vecs[5] = '{16'h1234, 4'b0100, 4'b0010, 1'b0, 1'b0, {7'h79, 7'h24, 7'h7F, 7'h19}, 4'b1011};
        vecs[6] = '{16'h0050, 4'h0, 4'h0, 1'b0, 1'b0, {7'h40, 7'h40, 7'h12, 7'h40}, 4'hF};
        vecs[7] = '{16'h8967, 4'hF, 4'h0, 1'b1, 1'b0, {7'h00, 7'h10, 7'h02, 7'h78}, 4'h0};
        vecs[8] = '{16'hEF00, 4'h0, 4'h0, 1'b1, 1'b1, {7'h06, 7'h0E, 7'h40, 7'h40}, 4'hF};

        rst_n   = 1'b0;
        d_data  = 16'h1234;
        d_dp    = 4'h0;
        d_blank = 4'h0;
        d_hex   = 1'b0;
        d_lzs   = 1'b0;
        #22;
        check("reset_a", {sel_a, dp_a, seg_a}, {4'hF, 1'b1, 7'h7F});
        check("reset_b", {sel_b, dp_b, seg_b}, {4'hF, 1'b1, 7'h7F});
        @(negedge clk);
        rst_n = 1'b1;

        // First frame: shadow blank is all ones, so no segment or dp may light.
        for (int j = 0; j < FRAME; j++) begin
            step();
            check("first_frame_dark", {4'h0, dp_a, seg_a}, {4'h0, 1'b1, 7'h7F});
        end
        // Second frame shows the inputs latched at the end of the first.
        for (int j = 0; j < FRAME; j++) begin
            step();
            if (j % DIV_T == 2)
                check("second_frame", {sel_a, dp_a, seg_a},
                      {~(4'b0001 << (j / DIV_T)), 1'b1, vecs[0].seg_exp[7*(j / DIV_T) +: 7]});
        end

        for (int v = 0; v < 9; v++) apply_vec(vecs[v], v);

        // Mid-frame data change must not tear the frame on screen.
        d_data = 16'h1111; d_dp = 4'h0; d_blank = 4'h0; d_hex = 1'b0; d_lzs = 1'b0;
        to_frame_start();
        to_frame_start();
        for (int j = 0; j < 2 * FRAME; j++) begin
            if (j == 6) d_data = 16'h2222;
            step();
            if (j % DIV_T == 2)
                check(j < FRAME ? "tear_old" : "tear_new", {4'h0, dp_a, seg_a},
                      {4'h0, 1'b1, (j < FRAME) ? 7'h79 : 7'h24});
        end

        // Asynchronous reset while digit 2 is selected.
        guard = 0;
        do begin
            step();
            guard++;
        end while (sel_a !== 4'hB && guard < 2 * FRAME);
        checks++;
        if (sel_a !== 4'hB) begin
            failures++;
            $display("FAIL wait_sel_b: sel=%h never reached b", sel_a);
        end
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_a", {sel_a, dp_a, seg_a}, {4'hF, 1'b1, 7'h7F});
        check("async_reset_b", {sel_b, dp_b, seg_b}, {4'hF, 1'b1, 7'h7F});
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", {sel_a, dp_a, seg_a}, {4'hF, 1'b1, 7'h7F});
        rst_n = 1'b1;
        model_reset();
        for (int j = 0; j < FRAME; j++) begin
            step();
            if (j % DIV_T == 2)
                check("post_reset_dark", {sel_a, dp_a, seg_a},
                      {~(4'b0001 << (j / DIV_T)), 1'b1, 7'h7F});
        end

        // Random traffic, checked every cycle against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 5) == 0) begin
                d_data = 16'($urandom);
                if ($urandom_range(0, 1) == 1)
                    d_data = d_data & 16'(32'hFFFF >> (4 * $urandom_range(1, 4)));
                d_dp    = 4'($urandom);
                d_blank = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                d_hex   = 1'($urandom);
                d_lzs   = 1'($urandom);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

endmodule
